// File: rtl/score_display_scanner_pkg.sv
// ---------------------------------------------------------------------------
// score_display_scanner_pkg
// Shared constants, FSM encoding and helpers for the score display path.
//   NUM_DIGITS / VALUE_MAX : display geometry and largest showable value
//   state_e                : bin2bcd_seq conversion FSM states
//   ONES..THOUSANDS        : digit-select indices as driven on tog
//   add3_if_ge5()          : double-dabble nibble correction
// ---------------------------------------------------------------------------
package score_display_scanner_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int VALUE_MAX  = 9999;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t ONES      = 2'd0;
    localparam digit_idx_t TENS      = 2'd1;
    localparam digit_idx_t HUNDREDS  = 2'd2;
    localparam digit_idx_t THOUSANDS = 2'd3;

    // A BCD nibble of 5 or more would become >= 10 after the next shift,
    // so it is pre-corrected by +3 to carry into the next digit instead.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/score_display_scanner_if.sv
// ---------------------------------------------------------------------------
// score_display_scanner_if
// Groups the request/status and display-side signals of the scanner.
//   value  : binary score (master -> slave)
//   update : convert request, sampled on clk rising edge (master -> slave)
//   busy   : conversion in progress (slave -> master)
//   done   : one-cycle pulse when new digits become visible (slave -> master)
//   tog    : digit select, 0 = ones ... 3 = thousands (slave -> master)
//   num    : BCD digit for the slot selected by tog (slave -> master)
// VALUE_W must match the VALUE_W of the connected score_display_scanner.
// ---------------------------------------------------------------------------
interface score_display_scanner_if #(
    parameter int VALUE_W = 14
);
    logic [VALUE_W-1:0] value;
    logic               update;
    logic               busy;
    logic               done;
    logic [1:0]         tog;
    logic [3:0]         num;

    modport master (
        output value, update,
        input  busy, done, tog, num
    );

    modport slave (
        input  value, update,
        output busy, done, tog, num
    );

endinterface

// File: rtl/score_display_scanner_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter with request queueing and a held,
// atomically updated set of display digits.
//   clk, rst   : clock, asynchronous active-high reset
//   value_i    : binary value, clamped to VALUE_MAX when captured
//   update_i   : conversion request; while busy it is remembered (one deep)
//   busy_o     : high whenever the FSM is not in IDLE
//   done_o     : one-cycle pulse in the cycle the new digits appear
//   digits_o   : displayed digits, index 0 = ones
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import score_display_scanner_pkg::*;
#(
    parameter int VALUE_W = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [VALUE_W-1:0]           value_i,
    input  logic                         update_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [NUM_DIGITS-1:0][3:0]   digits_o
);

    localparam int CNT_W = $clog2(VALUE_W + 1);

    state_e                       state_q,   state_d;
    logic                         pending_q, pending_d;
    logic [CNT_W-1:0]             count_q,   count_d;
    logic [VALUE_W-1:0]           bin_q,     bin_d;
    logic [BCD_W-1:0]             bcd_q,     bcd_d;
    logic [NUM_DIGITS-1:0][3:0]   digits_q,  digits_d;
    logic                         done_q,    done_d;

    logic [VALUE_W-1:0]           clamped;
    logic [BCD_W-1:0]             bcd_adj;

    // Compare in 32 bits so the clamp stays correct for any VALUE_W.
    always_comb begin
        clamped = (32'(value_i) > VALUE_MAX) ? VALUE_W'(VALUE_MAX) : value_i;
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = add3_if_ge5(bcd_q[4*i +: 4]);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        digits_d  = digits_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (update_i || pending_q) begin
                    bin_d     = clamped;
                    bcd_d     = '0;
                    count_d   = '0;
                    pending_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (update_i) begin
                    pending_d = 1'b1;
                end
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                count_d        = count_q + 1'b1;
                if (count_q == CNT_W'(VALUE_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (update_i) begin
                    pending_d = 1'b1;
                end
                // Digits change only here, all four together.
                digits_d = bcd_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // The digit registers are reset too: the display must read 0000 right
    // after reset, not power-up garbage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            count_q   <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            digits_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            digits_q  <= digits_d;
            done_q    <= done_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign digits_o = digits_q;

endmodule

// File: rtl/score_display_scanner.sv
// ---------------------------------------------------------------------------
// score_display_scanner
// Converts a binary score to four BCD digits and time-multiplexes them for
// the existing BCD-to-segment/anode decoder.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : score_display_scanner_if.slave
//              value/update in; busy/done/tog/num out
// Parameters:
//   REFRESH_CYCLES : clk cycles per digit slot (>= 2)
//   VALUE_W        : width of the binary score
// ---------------------------------------------------------------------------
module score_display_scanner
    import score_display_scanner_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100000,
    parameter int VALUE_W        = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    score_display_scanner_if.slave bus
);

    localparam int PRE_W = $clog2(REFRESH_CYCLES);

    logic [PRE_W-1:0]           prescaler_q, prescaler_d;
    digit_idx_t                 tog_q,       tog_d;
    logic [NUM_DIGITS-1:0][3:0] digits;

    bin2bcd_seq #(
        .VALUE_W (VALUE_W)
    ) u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .value_i  (bus.value),
        .update_i (bus.update),
        .busy_o   (bus.busy),
        .done_o   (bus.done),
        .digits_o (digits)
    );

    // Free-running refresh timer; deliberately unaware of the converter so
    // the scan cadence never stalls during a conversion.
    always_comb begin
        prescaler_d = prescaler_q + 1'b1;
        tog_d       = tog_q;
        if (prescaler_q == PRE_W'(REFRESH_CYCLES - 1)) begin
            prescaler_d = '0;
            tog_d       = tog_q + 1'b1;   // 3 -> 0 by natural wrap
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q <= '0;
            tog_q       <= ONES;
        end else begin
            prescaler_q <= prescaler_d;
            tog_q       <= tog_d;
        end
    end

    assign bus.tog = tog_q;
    assign bus.num = digits[tog_q];

endmodule

// File: tb/tb_score_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_score_display_scanner
// Directed self-checking bench for score_display_scanner with a short
// refresh period. The bench tracks clock edges since reset release to
// predict tog, and holds the expected displayed digits as BCD constants
// (nibble 0 = ones).
// ---------------------------------------------------------------------------
module tb_score_display_scanner;

    localparam int RC = 4;
    localparam int VW = 14;

    logic clk = 1'b0;
    logic rst;

    int cyc;
    int pass_cnt;
    int total_cnt;

    score_display_scanner_if #(.VALUE_W(VW)) bus ();

    score_display_scanner #(
        .REFRESH_CYCLES (RC),
        .VALUE_W        (VW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [1:0] exp_tog();
        return 2'((cyc / RC) % 4);
    endfunction

    function automatic logic [3:0] digit_of(input logic [15:0] digs, input logic [1:0] t);
        return digs[4*t +: 4];
    endfunction

    // Full conversion from the update edge k to two scan rounds after k+15.
    task automatic do_conversion(input string name, input logic [VW-1:0] v,
                                 input logic [15:0] prev, input logic [15:0] expd);
        logic [7:0] got, want;
        bus.value  = v;
        bus.update = 1'b1;
        tick();
        bus.update = 1'b0;
        total_cnt++;
        if ({bus.busy, bus.done} !== 2'b10)
            $display("FAIL %s start: busy/done=%b expected 10", name, {bus.busy, bus.done});
        else pass_cnt++;
        for (int c = 1; c <= 14; c++) begin
            tick();
            got  = {bus.tog, bus.busy, bus.done, bus.num};
            want = {exp_tog(), 2'b10, digit_of(prev, exp_tog())};
            total_cnt++;
            if (got !== want)
                $display("FAIL %s k+%0d: tog/busy/done/num=%h expected %h", name, c, got, want);
            else pass_cnt++;
        end
        tick();
        got  = {bus.tog, bus.busy, bus.done, bus.num};
        want = {exp_tog(), 2'b01, digit_of(expd, exp_tog())};
        total_cnt++;
        if (got !== want)
            $display("FAIL %s k+15: tog/busy/done/num=%h expected %h", name, got, want);
        else pass_cnt++;
        for (int c = 16; c < 16 + 2 * 4 * RC; c++) begin
            tick();
            got  = {bus.tog, bus.busy, bus.done, bus.num};
            want = {exp_tog(), 2'b00, digit_of(expd, exp_tog())};
            total_cnt++;
            if (got !== want)
                $display("FAIL %s scan k+%0d: tog/busy/done/num=%h expected %h", name, c, got, want);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.value  = '0;
        bus.update = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({bus.tog, bus.num, bus.busy, bus.done} !== 8'h00)
            $display("FAIL reset_initial: tog/num/busy/done=%h expected 00",
                     {bus.tog, bus.num, bus.busy, bus.done});
        else pass_cnt++;
        rst = 1'b0;
        cyc = 0;
        bus.value  = 14'd1;
        bus.update = 1'b1;
        tick();
        bus.update = 1'b0;
        repeat (4) tick();
        total_cnt++;
        if ({bus.tog, bus.busy} !== {exp_tog(), 1'b1})
            $display("FAIL reset_pre: tog/busy=%b expected %b", {bus.tog, bus.busy}, {exp_tog(), 1'b1});
        else pass_cnt++;
        // Assert reset between edges: outputs must clear without a clock.
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus.tog, bus.num, bus.busy, bus.done} !== 8'h00)
            $display("FAIL reset_async: tog/num/busy/done=%h expected 00",
                     {bus.tog, bus.num, bus.busy, bus.done});
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_conversion();
        do_conversion("conv_1234", 14'd1234, 16'h0000, 16'h1234);
    endtask

    task automatic test_clamp();
        do_conversion("clamp_12000", 14'd12000, 16'h1234, 16'h9999);
        do_conversion("zero", 14'd0, 16'h9999, 16'h0000);
    endtask

    task automatic test_queued();
        logic [7:0] got, want;
        logic [1:0] bd;
        logic [15:0] digs;
        bus.value  = 14'd42;
        bus.update = 1'b1;
        tick();
        bus.update = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (c == 5) begin
                bus.value  = 14'd7;
                bus.update = 1'b1;
            end
            tick();
            bus.update = 1'b0;
            if (c < 15)       begin bd = 2'b10; digs = 16'h0000; end
            else if (c == 15) begin bd = 2'b01; digs = 16'h0042; end
            else if (c < 31)  begin bd = 2'b10; digs = 16'h0042; end
            else if (c == 31) begin bd = 2'b01; digs = 16'h0007; end
            else              begin bd = 2'b00; digs = 16'h0007; end
            got  = {bus.tog, bus.busy, bus.done, bus.num};
            want = {exp_tog(), bd, digit_of(digs, exp_tog())};
            total_cnt++;
            if (got !== want)
                $display("FAIL queued k+%0d: tog/busy/done/num=%h expected %h", c, got, want);
            else pass_cnt++;
        end
    endtask

    task automatic test_refresh_wrap();
        int start;
        logic [1:0] first;
        start = cyc;
        first = exp_tog();
        for (int c = 1; c <= 5 * RC; c++) begin
            tick();
            total_cnt++;
            if (bus.tog !== exp_tog())
                $display("FAIL refresh_wrap +%0d: tog=%0d expected %0d", c, bus.tog, exp_tog());
            else pass_cnt++;
        end
        total_cnt++;
        if (cyc - start != 5 * RC || exp_tog() !== first + 2'd1)
            $display("FAIL refresh_span: edges=%0d expected %0d", cyc - start, 5 * RC);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_conversion();
        logic [7:0] got, want;
        bus.value  = 14'd5678;
        bus.update = 1'b1;
        tick();
        bus.update = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 5) bus.update = 1'b1;   // queue a second request
            tick();
            bus.update = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({bus.tog, bus.num, bus.busy, bus.done} !== 8'h00)
            $display("FAIL midreset_async: tog/num/busy/done=%h expected 00",
                     {bus.tog, bus.num, bus.busy, bus.done});
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        // Neither the aborted conversion nor the queued one may resurface.
        for (int c = 1; c <= 20; c++) begin
            tick();
            got  = {bus.tog, bus.busy, bus.done, bus.num};
            want = {exp_tog(), 2'b00, 4'h0};
            total_cnt++;
            if (got !== want)
                $display("FAIL midreset_idle +%0d: tog/busy/done/num=%h expected %h", c, got, want);
            else pass_cnt++;
        end
        do_conversion("fresh_5678", 14'd5678, 16'h0000, 16'h5678);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        cyc       = 0;
        test_reset();
        test_conversion();
        test_clamp();
        test_queued();
        test_refresh_wrap();
        test_reset_mid_conversion();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
